// File: rtl/rr_arb_mux_4_1_pkg.sv
// Shared channel count, select type and the wrapping pointer increment
// used by the round-robin arbiter and its priority encoder.
package arb_pkg;

  localparam int N_CH = 4;

  typedef logic [1:0] sel_t;

  function automatic sel_t rr_next(sel_t s);
    return s + sel_t'(1);
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Rotating-priority encoder: finds the first asserted request starting at
// ptr and wrapping, returning both its index and a one-hot grant.
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  sel_t            ptr,
  output logic            any,
  output sel_t            idx,
  output logic [N_CH-1:0] onehot
);

  sel_t cand;

  always_comb begin
    any    = 1'b0;
    idx    = ptr;
    onehot = '0;
    cand   = ptr;
    // Scan from the farthest candidate back so the nearest to ptr wins.
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = ptr + sel_t'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// Registered round-robin arbiter feeding a 4:1 data mux; the winner's data
// and index are captured into a valid/ready output register.
module rr_arb_mux_4_1
  import arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] in_valid,
  output logic [N_CH-1:0] in_ready,
  input  logic [W-1:0]    d0,
  input  logic [W-1:0]    d1,
  input  logic [W-1:0]    d2,
  input  logic [W-1:0]    d3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [1:0]      out_sel
);

  logic            valid_q, valid_d;
  logic [W-1:0]    data_q, data_d;
  sel_t            sel_q, sel_d;
  sel_t            ptr_q, ptr_d;

  logic            load;
  logic            pick_any;
  sel_t            pick_idx;
  logic [N_CH-1:0] pick_onehot;
  logic [W-1:0]    mux_data;

  rr_pick_4 u_pick (
    .req    (in_valid),
    .ptr    (ptr_q),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign load = !valid_q || out_ready;

  // Gated by rst_n so no producer sees an accept while the design is held.
  assign in_ready = (load && rst_n) ? pick_onehot : '0;

  always_comb begin
    mux_data = '0;
    case (pick_idx)
      2'd0:    mux_data = d0;
      2'd1:    mux_data = d1;
      2'd2:    mux_data = d2;
      default: mux_data = d3;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (pick_any) begin
        valid_d = 1'b1;
        data_d  = mux_data;
        sel_d   = pick_idx;
        ptr_d   = rr_next(pick_idx);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Bench for rr_arb_mux_4_1: directed vector table, hand-written reset
// sequences and randomized traffic checked against a queue-free reference model.
module tb_rr_arb_mux_4_1;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [W-1:0] d0, d1, d2, d3;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_ptr;
  int m_valid;
  int m_sel;
  int m_data;

  typedef struct {
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] exp_ready;
    logic       exp_valid;
    logic [1:0] exp_sel;
    logic [3:0] exp_data;
  } vec_t;

  vec_t vecs[13];

  rr_arb_mux_4_1 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // First requesting channel at or after p, going round the ring.
  function automatic int pick(input logic [3:0] iv, input int p);
    for (int k = 0; k < 4; k++) begin
      if (iv[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic int dval(input int ch);
    case (ch)
      0:       return int'(d0);
      1:       return int'(d1);
      2:       return int'(d2);
      default: return int'(d3);
    endcase
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_sel = 0; m_data = 0;
  endtask

  // Check one cycle against the model, clock it, advance the model.
  task automatic cycle(input string tag);
    int g;
    int ld;
    int er;
    #1;
    g  = pick(in_valid, m_ptr);
    ld = (m_valid == 0 || out_ready) ? 1 : 0;
    er = (ld != 0 && g >= 0) ? (1 << g) : 0;
    chk({tag, ".in_ready"},  int'(in_ready),  er);
    chk({tag, ".out_valid"}, int'(out_valid), m_valid);
    chk({tag, ".out_sel"},   int'(out_sel),   m_sel);
    chk({tag, ".out_data"},  int'(out_data),  m_data);
    @(posedge clk);
    if (ld != 0) begin
      if (g >= 0) begin
        m_valid = 1;
        m_sel   = g;
        m_data  = dval(g);
        m_ptr   = (g + 1) % 4;
      end else begin
        m_valid = 0;
      end
    end
    @(negedge clk);
    $display("cyc %s iv=%b ordy=%0d -> rdy=%b valid=%0d sel=%0d data=%h",
             tag, in_valid, out_ready, in_ready, out_valid, out_sel, out_data);
  endtask

  initial begin
    // Stream of scenario 3, stall of scenario 4, wrap/skip of scenario 5, drain.
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'h5};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'h6};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'h7};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'h8};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'h5};
    vecs[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 4'h5};
    vecs[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 4'h5};
    vecs[7]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 4'h5};
    vecs[8]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'h6};
    vecs[9]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 4'h7};
    vecs[10] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 4'h5};
    vecs[11] = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 4'h6};
    vecs[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 4'h6};

    rst_n = 1'b0;
    in_valid = '0; out_ready = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    model_reset();

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
      #1;
      chk("reset.in_ready",  int'(in_ready),  0);
      chk("reset.out_valid", int'(out_valid), 0);
      chk("reset.out_sel",   int'(out_sel),   0);
      chk("reset.out_data",  int'(out_data),  0);
      $display("reset cycle %0d: rdy=%b valid=%0d", i, in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = '0; out_ready = 1'b1;
    rst_n = 1'b1;

    // Single request on channel 2
    d0 = 4'h0; d1 = 4'h0; d2 = 4'hA; d3 = 4'h0;
    in_valid = 4'b0100;
    #1;
    chk("single.in_ready", int'(in_ready), 4'b0100);
    cycle("single");
    chk("single.out_valid", int'(out_valid), 1);
    chk("single.out_data",  int'(out_data),  4'hA);
    chk("single.out_sel",   int'(out_sel),   2);
    in_valid = 4'b0000;
    cycle("single_drain");

    // Restart from ptr=0 for the directed table
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    d0 = 4'h5; d1 = 4'h6; d2 = 4'h7; d3 = 4'h8;
    for (int i = 0; i < 13; i++) begin
      in_valid  = vecs[i].iv;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d.in_ready", i), int'(in_ready), int'(vecs[i].exp_ready));
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.out_valid", i), int'(out_valid), int'(vecs[i].exp_valid));
      chk($sformatf("vec%0d.out_sel", i),   int'(out_sel),   int'(vecs[i].exp_sel));
      chk($sformatf("vec%0d.out_data", i),  int'(out_data),  int'(vecs[i].exp_data));
    end

    // Reset in the middle of a stall
    in_valid = 4'b0010; out_ready = 1'b1;
    cycle("pre_stall");
    in_valid = 4'b1111; out_ready = 1'b0;
    #2;
    chk("stall.out_valid_before", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", int'(out_valid), 0);
    chk("midrst.in_ready",  int'(in_ready),  0);
    chk("midrst.out_sel",   int'(out_sel),   0);
    chk("midrst.out_data",  int'(out_data),  0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    out_ready = 1'b1;
    cycle("after_rst");
    chk("after_rst.out_sel",   int'(out_sel),   0);
    chk("after_rst.out_data",  int'(out_data),  4'h5);
    chk("after_rst.out_valid", int'(out_valid), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
      cycle($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
